// File: rtl/blake2_block_buffer.sv
// Packs a byte stream into 64-byte BLAKE2s blocks held in two ping-pong slots and
// hands them to the compression core. Define BLOCK_BUF_ZERO_PAD_EN to zero-fill the tail of the last block.
module blake2_block_buffer #(
    parameter int T_W = 64
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic           data_v_i,
    input  logic [7:0]     data_i,
    input  logic [5:0]     data_idx_i,
    input  logic           block_first_i,
    input  logic           block_last_i,
    input  logic [6:0]     kk_i,
    input  logic [T_W-1:0] ll_i,
    output logic           blk_v_o,
    input  logic           blk_ready_i,
    output logic [511:0]   blk_m_o,
    output logic [T_W-1:0] blk_t_o,
    output logic           blk_first_o,
    output logic           blk_last_o,
    output logic           overflow_o
);

    logic [511:0]   slot_m [2];
    logic [T_W-1:0] slot_t [2];
    logic [1:0]     slot_first;
    logic [1:0]     slot_last;
    logic [1:0]     full;
    logic           wr_slot;
    logic           rd_slot;
    logic [T_W-1:0] t_acc;
    logic           overflow;

    logic           wr_full;
    logic           wr_en;
    logic           complete;
    logic           accept;
    logic [T_W-1:0] t_next;
    logic [7:0]     byte_in;

    assign wr_full  = full[wr_slot];
    assign wr_en    = data_v_i & ~wr_full;
    assign complete = wr_en & (data_idx_i == 6'd63);
    assign accept   = full[rd_slot] & blk_ready_i;

    // Last block carries the total length (plus the key block); others advance by 64.
    always_comb begin
        if (block_last_i)
            t_next = ll_i + ((kk_i != 7'd0) ? T_W'(64) : {T_W{1'b0}});
        else
            t_next = (block_first_i ? {T_W{1'b0}} : t_acc) + T_W'(64);
    end

`ifdef BLOCK_BUF_ZERO_PAD_EN
    logic [6:0] pad_start;

    // A keyed empty message ends on the key block, which must keep its bytes.
    always_comb begin
        if (ll_i == {T_W{1'b0}})
            pad_start = (kk_i == 7'd0) ? 7'd0 : 7'd64;
        else if (ll_i[5:0] == 6'd0)
            pad_start = 7'd64;
        else
            pad_start = {1'b0, ll_i[5:0]};
        byte_in = (block_last_i && ({1'b0, data_idx_i} >= pad_start)) ? 8'h00 : data_i;
    end
`else
    assign byte_in = data_i;
`endif

    always_ff @(posedge clk) begin
        if (wr_en)
            slot_m[wr_slot][{data_idx_i, 3'b000} +: 8] <= byte_in;
    end

    // A completing slot is never full and an accepted slot always is, so the two never collide.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            full       <= 2'b00;
            wr_slot    <= 1'b0;
            rd_slot    <= 1'b0;
            t_acc      <= '0;
            overflow   <= 1'b0;
            slot_t[0]  <= '0;
            slot_t[1]  <= '0;
            slot_first <= 2'b00;
            slot_last  <= 2'b00;
        end else begin
            if (data_v_i && wr_full)
                overflow <= 1'b1;
            if (complete) begin
                full[wr_slot]       <= 1'b1;
                slot_t[wr_slot]     <= t_next;
                slot_first[wr_slot] <= block_first_i;
                slot_last[wr_slot]  <= block_last_i;
                wr_slot             <= ~wr_slot;
                t_acc               <= block_last_i ? {T_W{1'b0}} : t_next;
            end
            if (accept) begin
                full[rd_slot] <= 1'b0;
                rd_slot       <= ~rd_slot;
            end
        end
    end

    assign blk_v_o     = full[rd_slot];
    assign blk_m_o     = slot_m[rd_slot];
    assign blk_t_o     = slot_t[rd_slot];
    assign blk_first_o = slot_first[rd_slot];
    assign blk_last_o  = slot_last[rd_slot];
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_blake2_block_buffer.sv
// Self-checking bench for blake2_block_buffer: message-level reference model,
// randomized payloads, backpressure and gaps. Honours BLOCK_BUF_ZERO_PAD_EN.
module tb_blake2_block_buffer;

`ifdef BLOCK_BUF_ZERO_PAD_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    typedef struct {
        logic [511:0] m;
        logic [63:0]  t;
        logic         first;
        logic         last;
    } blk_t;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic         data_v_i = 1'b0;
    logic [7:0]   data_i = 8'h00;
    logic [5:0]   data_idx_i = 6'd0;
    logic         block_first_i = 1'b0;
    logic         block_last_i = 1'b0;
    logic [6:0]   kk_i = 7'd0;
    logic [63:0]  ll_i = 64'd0;
    logic         blk_v_o;
    logic         blk_ready_i = 1'b0;
    logic [511:0] blk_m_o;
    logic [63:0]  blk_t_o;
    logic         blk_first_o;
    logic         blk_last_o;
    logic         overflow_o;

    int   tests = 0;
    int   fails = 0;
    int   sent_blocks = 0;
    int   acc_count = 0;
    bit   done = 1'b0;
    blk_t got[$];
    blk_t snd_q[$];
    blk_t exp_q[$];

    blake2_block_buffer #(.T_W(64)) dut (
        .clk(clk), .nreset(nreset),
        .data_v_i(data_v_i), .data_i(data_i), .data_idx_i(data_idx_i),
        .block_first_i(block_first_i), .block_last_i(block_last_i),
        .kk_i(kk_i), .ll_i(ll_i),
        .blk_v_o(blk_v_o), .blk_ready_i(blk_ready_i), .blk_m_o(blk_m_o),
        .blk_t_o(blk_t_o), .blk_first_o(blk_first_o), .blk_last_o(blk_last_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Records every block the core will take at the coming edge.
    always @(negedge clk) begin
        if (nreset && blk_v_o && blk_ready_i) begin
            blk_t b;
            b.m = blk_m_o; b.t = blk_t_o; b.first = blk_first_o; b.last = blk_last_o;
            got.push_back(b);
            acc_count++;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: split a message into key block + data blocks and derive flags and t.
    function automatic void build_message(input int kk, input int ll);
        int nd, nb, bi;
        logic [511:0] sm, em;
        logic [7:0] bv;
        blk_t b;
        snd_q.delete(); exp_q.delete();
        nd = (ll == 0) ? ((kk == 0) ? 1 : 0) : (ll + 63) / 64;
        nb = nd + ((kk != 0) ? 1 : 0);
        bi = 0;
        if (kk != 0) begin
            sm = '0;
            for (int j = 0; j < kk; j++) sm[8*j +: 8] = 8'($urandom);
            b.m = sm; b.first = 1'b1; b.last = (nb == 1);
            b.t = b.last ? 64'(ll + 64) : 64'd64;
            snd_q.push_back(b); exp_q.push_back(b);
            bi++;
        end
        for (int i = 0; i < nd; i++) begin
            for (int j = 0; j < 64; j++) begin
                bv = 8'($urandom);
                sm[8*j +: 8] = bv;
                em[8*j +: 8] = (ZP && (64*i + j >= ll)) ? 8'h00 : bv;
            end
            b.first = (bi == 0); b.last = (bi == nb - 1);
            b.t = b.last ? 64'(ll + ((kk != 0) ? 64 : 0)) : 64'(64 * (bi + 1));
            b.m = sm; snd_q.push_back(b);
            b.m = em; exp_q.push_back(b);
            bi++;
        end
    endfunction

    task automatic put_byte(input logic [7:0] d, input logic [5:0] idx, input logic f, input logic l);
        @(posedge clk); #1;
        data_v_i = 1'b1; data_i = d; data_idx_i = idx; block_first_i = f; block_last_i = l;
        if (idx == 6'd63) sent_blocks++;
    endtask

    // Host-side byte sender: optional idle gaps with garbage inputs, never overruns both slots.
    task automatic send_byte(input logic [7:0] d, input logic [5:0] idx, input logic f, input logic l,
                             input bit gaps);
        int waited = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            data_v_i = 1'b0; data_i = 8'($urandom); data_idx_i = 6'($urandom);
            block_first_i = 1'($urandom); block_last_i = 1'($urandom);
        end
        while ((sent_blocks - acc_count >= 2) && waited < 300) begin
            @(posedge clk); #1;
            data_v_i = 1'b0;
            waited++;
        end
        if (waited >= 300) begin
            tests++; fails++;
            $display("FAIL slot_wait: buffer stayed full for %0d cycles", waited);
        end
        put_byte(d, idx, f, l);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nreset = 1'b0; data_v_i = 1'b0; blk_ready_i = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        sent_blocks = 0; acc_count = 0; got.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b0) begin fails++; $display("FAIL reset_v: got %b exp 0", blk_v_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b exp 0", overflow_o); end
        tests++; if (blk_t_o !== 64'd0) begin fails++; $display("FAIL reset_t: got %0d exp 0", blk_t_o); end
        tests++; if (blk_first_o !== 1'b0) begin fails++; $display("FAIL reset_first: got %b exp 0", blk_first_o); end
        tests++; if (blk_last_o !== 1'b0) begin fails++; $display("FAIL reset_last: got %b exp 0", blk_last_o); end
    endtask

    task automatic test_single_block();
        do_reset();
        kk_i = 7'd0; ll_i = 64'd3;
        for (int i = 0; i < 64; i++) put_byte((i < 3) ? 8'(8'h61 + i) : 8'h00, 6'(i), 1'b1, 1'b1);
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b0) begin fails++; $display("FAIL single_early_v: got %b exp 0", blk_v_o); end
        @(posedge clk); #1 data_v_i = 1'b0;
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b1) begin fails++; $display("FAIL single_v: got %b exp 1", blk_v_o); end
        tests++; if (blk_m_o[31:0] !== 32'h00636261) begin fails++; $display("FAIL single_m0: got %h exp 00636261", blk_m_o[31:0]); end
        tests++; if (blk_t_o !== 64'd3) begin fails++; $display("FAIL single_t: got %0d exp 3", blk_t_o); end
        tests++; if ({blk_first_o, blk_last_o} !== 2'b11) begin fails++; $display("FAIL single_flags: got %b exp 11", {blk_first_o, blk_last_o}); end
        @(posedge clk); #1 blk_ready_i = 1'b1;
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b1) begin fails++; $display("FAIL single_hold_v: got %b exp 1", blk_v_o); end
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b0) begin fails++; $display("FAIL single_pop_v: got %b exp 0", blk_v_o); end
        blk_ready_i = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [511:0] a, b;
        int w;
        do_reset();
        for (int i = 0; i < 16; i++) begin a[32*i +: 32] = $urandom; b[32*i +: 32] = $urandom; end
        kk_i = 7'd0; ll_i = 64'd128;
        for (int i = 0; i < 64; i++) put_byte(a[8*i +: 8], 6'(i), 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) put_byte(b[8*i +: 8], 6'(i), 1'b0, 1'b1);
        @(posedge clk); #1 data_v_i = 1'b0;
        @(negedge clk);
        tests++; if (blk_v_o !== 1'b1) begin fails++; $display("FAIL bp_v: got %b exp 1", blk_v_o); end
        tests++; if (blk_m_o !== a) begin fails++; $display("FAIL bp_hold_a: got %h exp %h", blk_m_o, a); end
        tests++; if (blk_t_o !== 64'd64) begin fails++; $display("FAIL bp_t_a: got %0d exp 64", blk_t_o); end
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL bp_no_ovf: got %b exp 0", overflow_o); end
        put_byte(8'h5A, 6'd0, 1'b0, 1'b0);
        @(posedge clk); #1 data_v_i = 1'b0;
        @(negedge clk);
        tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL bp_ovf: got %b exp 1", overflow_o); end
        tests++; if (blk_m_o !== a) begin fails++; $display("FAIL bp_still_a: got %h exp %h", blk_m_o, a); end
        got.delete();
        @(posedge clk); #1 blk_ready_i = 1'b1;
        w = 0;
        while (got.size() < 2 && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        tests++;
        if (got.size() !== 2) begin
            fails++; $display("FAIL bp_count: got %0d blocks exp 2", got.size());
        end else begin
            tests++; if (got[0].m !== a) begin fails++; $display("FAIL bp_out_a: got %h exp %h", got[0].m, a); end
            tests++; if (got[1].m !== b) begin fails++; $display("FAIL bp_out_b: got %h exp %h", got[1].m, b); end
            tests++; if (got[1].t !== 64'd128) begin fails++; $display("FAIL bp_t_b: got %0d exp 128", got[1].t); end
            tests++; if ({got[1].first, got[1].last} !== 2'b01) begin fails++; $display("FAIL bp_flags_b: got %b exp 01", {got[1].first, got[1].last}); end
        end
        tests++; if (overflow_o !== 1'b1) begin fails++; $display("FAIL bp_ovf_sticky: got %b exp 1", overflow_o); end
        blk_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid_block();
        logic [511:0] c;
        int w;
        do_reset();
        blk_ready_i = 1'b1; kk_i = 7'd0; ll_i = 64'd1000;
        for (int i = 0; i < 30; i++) put_byte(8'($urandom), 6'(i), 1'b1, 1'b0);
        @(posedge clk); #1;
        nreset = 1'b0; data_v_i = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1; sent_blocks = 0; acc_count = 0; got.delete();
        for (int i = 0; i < 16; i++) c[32*i +: 32] = $urandom;
        for (int i = 0; i < 64; i++) put_byte(c[8*i +: 8], 6'(i), 1'b1, 1'b0);
        @(posedge clk); #1 data_v_i = 1'b0;
        w = 0;
        while (got.size() < 1 && w < 20) begin @(negedge clk); w++; end
        repeat (4) @(negedge clk);
        tests++;
        if (got.size() !== 1) begin
            fails++; $display("FAIL rstmid_count: got %0d blocks exp 1", got.size());
        end else begin
            tests++; if (got[0].m !== c) begin fails++; $display("FAIL rstmid_m: got %h exp %h", got[0].m, c); end
            tests++; if (got[0].t !== 64'd64) begin fails++; $display("FAIL rstmid_t: got %0d exp 64", got[0].t); end
            tests++; if ({got[0].first, got[0].last} !== 2'b10) begin fails++; $display("FAIL rstmid_flags: got %b exp 10", {got[0].first, got[0].last}); end
        end
        blk_ready_i = 1'b0;
    endtask

    task automatic test_zero_pad();
        logic [487:0] exp_pad;
        do_reset();
        exp_pad = ZP ? '0 : '1;
        kk_i = 7'd0; ll_i = 64'd3;
        for (int i = 0; i < 64; i++) put_byte((i < 3) ? 8'(8'h61 + i) : 8'hFF, 6'(i), 1'b1, 1'b1);
        @(posedge clk); #1 data_v_i = 1'b0;
        @(negedge clk);
        tests++; if (blk_m_o[23:0] !== 24'h636261) begin fails++; $display("FAIL zpad_msg: got %h exp 636261", blk_m_o[23:0]); end
        tests++; if (blk_m_o[511:24] !== exp_pad) begin fails++; $display("FAIL zpad_tail: got %h exp %h", blk_m_o[511:24], exp_pad); end
    endtask

    task automatic test_messages();
        int tab_kk[7] = '{0, 32, 0, 16, 0, 0, 64};
        int tab_ll[7] = '{150, 10, 0, 0, 64, 128, 65};
        bit tab_rr[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int n = 0; n < 14; n++) begin
            int kk, ll, w, nexp;
            bit rr, gaps;
            if (n < 7) begin
                kk = tab_kk[n]; ll = tab_ll[n]; rr = tab_rr[n]; gaps = (n >= 2);
            end else begin
                kk = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 64));
                ll = int'($urandom_range(0, 300)); rr = 1'b1; gaps = 1'b1;
            end
            kk_i = 7'(kk); ll_i = 64'(ll);
            build_message(kk, ll);
            nexp = exp_q.size();
            got.delete(); done = 1'b0;
            fork
                begin
                    for (int k = 0; k < snd_q.size(); k++) begin
                        logic [511:0] sm;
                        sm = snd_q[k].m;
                        for (int j = 0; j < 64; j++)
                            send_byte(sm[8*j +: 8], 6'(j), snd_q[k].first, snd_q[k].last, gaps);
                    end
                    @(posedge clk); #1 data_v_i = 1'b0;
                    done = 1'b1;
                end
                begin
                    if (rr) begin
                        while (!done) begin @(posedge clk); #1 blk_ready_i = 1'($urandom); end
                    end else begin
                        blk_ready_i = 1'b1;
                    end
                end
            join
            blk_ready_i = 1'b1;
            w = 0;
            while (got.size() < nexp && w < 500) begin @(negedge clk); w++; end
            repeat (3) @(negedge clk);
            tests++;
            if (got.size() !== nexp) begin
                fails++; $display("FAIL msg%0d_count: got %0d blocks exp %0d (kk=%0d ll=%0d)", n, got.size(), nexp, kk, ll);
            end
            for (int k = 0; k < got.size() && k < nexp; k++) begin
                tests++; if (got[k].m !== exp_q[k].m) begin fails++; $display("FAIL msg%0d_blk%0d_m: got %h exp %h", n, k, got[k].m, exp_q[k].m); end
                tests++; if (got[k].t !== exp_q[k].t) begin fails++; $display("FAIL msg%0d_blk%0d_t: got %0d exp %0d", n, k, got[k].t, exp_q[k].t); end
                tests++; if (got[k].first !== exp_q[k].first) begin fails++; $display("FAIL msg%0d_blk%0d_first: got %b exp %b", n, k, got[k].first, exp_q[k].first); end
                tests++; if (got[k].last !== exp_q[k].last) begin fails++; $display("FAIL msg%0d_blk%0d_last: got %b exp %b", n, k, got[k].last, exp_q[k].last); end
            end
            tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL msg%0d_ovf: got %b exp 0", n, overflow_o); end
            blk_ready_i = 1'b0;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_single_block();
        test_backpressure();
        test_reset_mid_block();
        test_zero_pad();
        test_messages();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
